// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU with valid/ready handshake on both sides.
// Define SIMD_ALU_SAT_EN to build the signed saturating add/sub opcodes (10/11).
module simd_alu_pipe #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      inst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_PADD   = 4'd1,
    OP_PSUB   = 4'd2,
    OP_PSLL   = 4'd3,
    OP_PSRL   = 4'd4,
    OP_PSRA   = 4'd5,
    OP_PCMPEQ = 4'd6,
    OP_PCMPGT = 4'd7,
    OP_PADDS  = 4'd10,
    OP_PSUBS  = 4'd11
  } op_e;

  logic             s1_valid_q, s1_err_q, s1_imm_flag_q;
  logic [3:0]       s1_op_q;
  logic [1:0]       s1_mode_q;
  logic [7:0]       s1_imm_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_valid_q, s2_err_q, s2_err_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s1_adv, s2_adv, in_illegal;
  logic [3:0][WIDTH-1:0] mode_res;

  // Ready ripples back from the consumer only; in_valid never feeds in_ready.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    in_illegal = 1'b1;
    case (inst[15:12])
      OP_NOP, OP_PADD, OP_PSUB, OP_PSLL, OP_PSRL,
      OP_PSRA, OP_PCMPEQ, OP_PCMPGT: in_illegal = 1'b0;
`ifdef SIMD_ALU_SAT_EN
      OP_PADDS, OP_PSUBS:            in_illegal = 1'b0;
`endif
      default: ;
    endcase
    if (inst[11]) in_illegal = 1'b1;
  end

  // NOTE: the wide operand/result registers are reset as well, so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_err_q      <= 1'b0;
      s1_op_q       <= 4'd0;
      s1_mode_q     <= 2'd0;
      s1_imm_flag_q <= 1'b0;
      s1_imm_q      <= 8'd0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
    end else if (s1_adv) begin
      // NOTE: sequential state uses non-blocking assignments so both stages see pre-edge values.
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_err_q      <= in_illegal;
        s1_op_q       <= inst[15:12];
        s1_mode_q     <= inst[10:9];
        s1_imm_flag_q <= inst[8];
        s1_imm_q      <= inst[7:0];
        s1_a_q        <= in_a;
        s1_b_q        <= in_b;
      end
    end
  end

  // One result vector per lane width; the registered data_mode picks one.
  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int LW = 8 << m;
    for (genvar l = 0; l < WIDTH / LW; l++) begin : g_lane
      logic [LW-1:0] a, b, bo, r;
      logic [7:0]    sh;
`ifdef SIMD_ALU_SAT_EN
      logic [LW:0]   sum;
`endif
      assign a  = s1_a_q[l*LW +: LW];
      assign b  = s1_b_q[l*LW +: LW];
      assign bo = s1_imm_flag_q ? LW'(s1_imm_q) : b;
      assign sh = s1_imm_flag_q ? s1_imm_q : b[7:0];

      always_comb begin
        r = '0;
`ifdef SIMD_ALU_SAT_EN
        sum = '0;
`endif
        case (s1_op_q)
          OP_PADD:   r = a + bo;
          OP_PSUB:   r = a - bo;
          OP_PSLL:   r = (32'(sh) >= LW) ? '0 : a << sh;
          OP_PSRL:   r = (32'(sh) >= LW) ? '0 : a >> sh;
          OP_PSRA:   r = (32'(sh) >= LW) ? {LW{a[LW-1]}} : LW'($signed(a) >>> sh);
          OP_PCMPEQ: r = {LW{a == b}};
          OP_PCMPGT: r = {LW{$signed(a) > $signed(b)}};
`ifdef SIMD_ALU_SAT_EN
          OP_PADDS, OP_PSUBS: begin
            // One guard bit: overflow shows up as a mismatch of the top two bits.
            sum = (s1_op_q == OP_PADDS) ? {a[LW-1], a} + {bo[LW-1], bo}
                                        : {a[LW-1], a} - {bo[LW-1], bo};
            if (sum[LW] != sum[LW-1])
              r = sum[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
            else
              r = sum[LW-1:0];
          end
`endif
          default: r = '0;
        endcase
      end

      assign mode_res[m][l*LW +: LW] = r;
    end
  end

  assign s2_data_d = s1_err_q ? '0 : mode_res[s1_mode_q];
  assign s2_err_d  = s1_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_data_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

endmodule
